cpu_exec_core: RTL and testbench
================================

Name: cpu_exec_core

Overview:
- Execute/memory stage of a single-cycle 32-bit MIPS-subset CPU.
- Merges three functions: opcode decoder (control unit), 32-bit ALU with zero flag, and data memory with writeback mux (data saver).
- Sits between the register file/sign-extender and the next-PC logic.
- Decode, ALU and memory read are combinational. Only data-memory writes are clocked.

Parameters:
- MEM_WORDS, 64, number of 32-bit data-memory words; word address = result[7:2], upper address bits ignored.

Ports:
- click  in  1  system clock; memory writes on rising edge.
- reset  in  1  asynchronous active-high reset; clears data memory.
- opcode  in  6  instruction[31:26].
- readData1  in  32  register rs value (ALU operand A).
- readData2  in  32  register rt value (ALU B when ALUSrcB=0; store data).
- immediate_32  in  32  extended immediate (ALU B when ALUSrcB=1).
- ALUSrcB  out  1  1 = B is immediate_32.
- ALUM2Reg  out  1  1 = writeback from memory, 0 = from ALU.
- RegWre  out  1  register-file write enable.
- InsMemRW  out  1  instruction-memory read; constant 1.
- DataMemRW  out  1  1 = data-memory write.
- ExtSel  out  1  1 = sign-extend, 0 = zero-extend.
- PCSrc  out  1  1 = take branch.
- RegOut  out  1  destination select: 1 = rd, 0 = rt.
- PCWre  out  1  PC update enable; 0 halts.
- ALUFlag  out  3  ALU operation select.
- zero  out  1  result == 0.
- result  out  32  ALU result / memory byte address.
- DataOut  out  32  data-memory read word.
- write_data  out  32  register writeback value.

Behaviour:
- ALU ops by ALUFlag (B = immediate_32 if ALUSrcB else readData2), 32-bit, carry/overflow discarded (wraps):
  - 000: A+B
  - 001: A-B
  - 010: B-A
  - 011: A|B
  - 100: A&B
  - 101: ~A&B
  - 110: A^B
  - 111: ~(A^B)
- zero = (result == 32'h0).
- Decode table; unlisted signals are 0. InsMemRW=1 and PCWre=1 unless stated.
  - 000000 add: RegWre, RegOut, ALUFlag 000.
  - 000001 addi: RegWre, ALUSrcB, ExtSel, ALUFlag 000.
  - 000010 sub: RegWre, RegOut, ALUFlag 001.
  - 010000 ori: RegWre, ALUSrcB, ExtSel=0, ALUFlag 011.
  - 010001 and: RegWre, RegOut, ALUFlag 100.
  - 010010 or: RegWre, RegOut, ALUFlag 011.
  - 100000 move: RegWre, RegOut, ALUFlag 000 (rs + $0).
  - 100110 sw: ALUSrcB, ExtSel, DataMemRW, ALUFlag 000.
  - 100111 lw: RegWre, ALUSrcB, ExtSel, ALUM2Reg, ALUFlag 000.
  - 110000 beq: ExtSel, ALUFlag 001, PCSrc = zero.
  - 111111 halt: PCWre=0, all write enables 0.
  - any other opcode: NOP (all enables 0, ALUFlag 000, PCWre=1).
- PCSrc is combinational from zero. There is no loop, because ALUFlag depends only on opcode.
- Memory read:
  - DataOut = mem[result[7:2]], combinational, always driven.
- Memory write:
  - On posedge click with DataMemRW=1, mem[result[7:2]] <= readData2.
  - New value visible on DataOut right after the edge.
  - result[1:0] ignored (no misaligned access).
- Writeback: write_data = ALUM2Reg ? DataOut : result.
- Reset:
  - reset=1 asynchronously clears all memory words to 0 and blocks writes while high.
  - Combinational outputs are unaffected except that DataOut becomes 0.
- Simultaneous reset and write: reset wins; the word stays 0.
- Read during write cycle: DataOut shows the old value until the edge.

Test Plan:
- Reset, then opcode 000000, A=5, B=7 → result=12, zero=0, RegWre=1, RegOut=1, write_data=12, PCWre=1.
- sub: A=B=0x1234 → result=0, zero=1. sub: A=3, B=5 → result=0xFFFFFFFE.
- ori: A=0x00F0, imm=0x000F → result=0xFF, ExtSel=0, ALUSrcB=1. addi: A=0xFFFFFFFF, imm=1 → result=0, zero=1 (wrap).
- sw: A=8, imm=4, readData2=0xDEADBEEF, one click edge → mem word 3 = 0xDEADBEEF. Then lw with the same address → DataOut=write_data=0xDEADBEEF, ALUM2Reg=1, DataMemRW=0.
- beq: A=B=9 → PCSrc=1. A=9, B=8 → PCSrc=0. RegWre=0 and DataMemRW=0 in both cases.
- halt (111111) → PCWre=0, RegWre=0, DataMemRW=0. Opcode 001111 → NOP. Assert reset mid-run after a store → DataOut=0 at the stored address; a store issued while reset is high is dropped.

Source files
------------

// File: rtl/cpu_exec_core.sv
// cpu_exec_core: execute/memory stage with opcode decode, 32-bit ALU, data memory and writeback mux
module cpu_exec_core #(
   parameter int MEM_WORDS = 64
) (
   input  logic        click,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic [31:0] readData1,
   input  logic [31:0] readData2,
   input  logic [31:0] immediate_32,
   output logic        ALUSrcB,
   output logic        ALUM2Reg,
   output logic        RegWre,
   output logic        InsMemRW,
   output logic        DataMemRW,
   output logic        ExtSel,
   output logic        PCSrc,
   output logic        RegOut,
   output logic        PCWre,
   output logic [2:0]  ALUFlag,
   output logic        zero,
   output logic [31:0] result,
   output logic [31:0] DataOut,
   output logic [31:0] write_data
);
   localparam int AW = $clog2(MEM_WORDS);
   logic [31:0]   mem [MEM_WORDS];
   logic [31:0]   alu_b;
   logic [AW-1:0] addr;
   logic          branch;
   logic          unused_bits;
   // control decode; ALUFlag depends only on opcode so PCSrc has no loop through zero
   always_comb begin
      ALUSrcB   = 1'b0;
      ALUM2Reg  = 1'b0;
      RegWre    = 1'b0;
      InsMemRW  = 1'b1;
      DataMemRW = 1'b0;
      ExtSel    = 1'b0;
      RegOut    = 1'b0;
      PCWre     = 1'b1;
      ALUFlag   = 3'b000;
      branch    = 1'b0;
      case (opcode)
         6'b000000, 6'b100000: begin RegWre = 1'b1; RegOut = 1'b1; end
         6'b000001: begin RegWre = 1'b1; ALUSrcB = 1'b1; ExtSel = 1'b1; end
         6'b000010: begin RegWre = 1'b1; RegOut = 1'b1; ALUFlag = 3'b001; end
         6'b010000: begin RegWre = 1'b1; ALUSrcB = 1'b1; ALUFlag = 3'b011; end
         6'b010001: begin RegWre = 1'b1; RegOut = 1'b1; ALUFlag = 3'b100; end
         6'b010010: begin RegWre = 1'b1; RegOut = 1'b1; ALUFlag = 3'b011; end
         6'b100110: begin ALUSrcB = 1'b1; ExtSel = 1'b1; DataMemRW = 1'b1; end
         6'b100111: begin RegWre = 1'b1; ALUSrcB = 1'b1; ExtSel = 1'b1; ALUM2Reg = 1'b1; end
         6'b110000: begin ExtSel = 1'b1; ALUFlag = 3'b001; branch = 1'b1; end
         6'b111111: PCWre = 1'b0;
         default: ;
      endcase
   end
   assign alu_b = ALUSrcB ? immediate_32 : readData2;
   // ALU; carries and overflow wrap silently
   always_comb begin
      case (ALUFlag)
         3'b000: result = readData1 + alu_b;
         3'b001: result = readData1 - alu_b;
         3'b010: result = alu_b - readData1;
         3'b011: result = readData1 | alu_b;
         3'b100: result = readData1 & alu_b;
         3'b101: result = ~readData1 & alu_b;
         3'b110: result = readData1 ^ alu_b;
         default: result = ~(readData1 ^ alu_b);
      endcase
   end
   assign zero        = (result == 32'h0);
   assign PCSrc       = branch & zero;
   assign addr        = result[AW+1:2];
   assign unused_bits = ^{result[31:AW+2], result[1:0]};
   assign DataOut     = mem[addr];
   assign write_data  = ALUM2Reg ? DataOut : result;
   // word-wide store; reset clears every word and suppresses a coincident store
   always_ff @(posedge click or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
      end else if (DataMemRW) begin
         mem[addr] <= readData2;
      end
   end
endmodule

// File: tb/tb_cpu_exec_core.sv
// tb_cpu_exec_core: vector table, store/load/reset sequences and randomized checks against a reference model
module tb_cpu_exec_core;
   logic        click = 1'b0;
   logic        reset = 1'b1;
   logic [5:0]  opcode = '0;
   logic [31:0] readData1 = '0, readData2 = '0, immediate_32 = '0;
   logic        ALUSrcB, ALUM2Reg, RegWre, InsMemRW, DataMemRW, ExtSel, PCSrc, RegOut, PCWre, zero;
   logic [2:0]  ALUFlag;
   logic [31:0] result, DataOut, write_data;
   int checks = 0;
   int errors = 0;
   logic [31:0] mm [64];

   cpu_exec_core #(.MEM_WORDS(64)) dut (
      .click(click), .reset(reset), .opcode(opcode), .readData1(readData1),
      .readData2(readData2), .immediate_32(immediate_32), .ALUSrcB(ALUSrcB),
      .ALUM2Reg(ALUM2Reg), .RegWre(RegWre), .InsMemRW(InsMemRW), .DataMemRW(DataMemRW),
      .ExtSel(ExtSel), .PCSrc(PCSrc), .RegOut(RegOut), .PCWre(PCWre), .ALUFlag(ALUFlag),
      .zero(zero), .result(result), .DataOut(DataOut), .write_data(write_data)
   );

   always #5 click = ~click;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   // control word {ALUSrcB,ALUM2Reg,RegWre,InsMemRW,DataMemRW,ExtSel,RegOut,PCWre,ALUFlag}
   function automatic logic [10:0] ref_ctrl(input logic [5:0] op);
      case (op)
         6'b000000: return 11'b0011_0011_000;
         6'b000001: return 11'b1011_0101_000;
         6'b000010: return 11'b0011_0011_001;
         6'b010000: return 11'b1011_0001_011;
         6'b010001: return 11'b0011_0011_100;
         6'b010010: return 11'b0011_0011_011;
         6'b100000: return 11'b0011_0011_000;
         6'b100110: return 11'b1001_1101_000;
         6'b100111: return 11'b1111_0101_000;
         6'b110000: return 11'b0001_0101_001;
         6'b111111: return 11'b0001_0000_000;
         default:   return 11'b0001_0001_000;
      endcase
   endfunction

   function automatic logic [31:0] ref_alu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      case (f)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return b - a;
         3'd3: return a | b;
         3'd4: return a & b;
         3'd5: return ~a & b;
         3'd6: return a ^ b;
         default: return ~(a ^ b);
      endcase
   endfunction

   function automatic logic [31:0] ref_result();
      logic [10:0] c;
      c = ref_ctrl(opcode);
      return ref_alu(c[2:0], readData1, c[10] ? immediate_32 : readData2);
   endfunction

   task automatic check_all(input string tag);
      logic [10:0] c;
      logic [31:0] r, d;
      c = ref_ctrl(opcode);
      r = ref_result();
      d = mm[r[7:2]];
      chk({tag, ".ctrl"}, {21'd0, ALUSrcB, ALUM2Reg, RegWre, InsMemRW, DataMemRW, ExtSel, RegOut, PCWre, ALUFlag}, {21'd0, c});
      chk({tag, ".result"}, result, r);
      chk({tag, ".zero"}, {31'd0, zero}, {31'd0, r == 0});
      chk({tag, ".pcsrc"}, {31'd0, PCSrc}, {31'd0, opcode == 6'b110000 && r == 0});
      chk({tag, ".dataout"}, DataOut, d);
      chk({tag, ".write_data"}, write_data, c[9] ? d : r);
   endtask

   typedef struct {
      logic [5:0]  op;
      logic [31:0] a, b, imm, res;
      logic        z, pcs;
   } vec_t;
   vec_t tbl[13];

   initial begin
      tbl[0]  = '{6'b000000, 32'd5, 32'd7, 32'd0, 32'd12, 1'b0, 1'b0};
      tbl[1]  = '{6'b000010, 32'h1234, 32'h1234, 32'd0, 32'd0, 1'b1, 1'b0};
      tbl[2]  = '{6'b000010, 32'd3, 32'd5, 32'd0, 32'hFFFF_FFFE, 1'b0, 1'b0};
      tbl[3]  = '{6'b010000, 32'h00F0, 32'h1111, 32'h000F, 32'hFF, 1'b0, 1'b0};
      tbl[4]  = '{6'b000001, 32'hFFFF_FFFF, 32'h55, 32'd1, 32'd0, 1'b1, 1'b0};
      tbl[5]  = '{6'b110000, 32'd9, 32'd9, 32'd77, 32'd0, 1'b1, 1'b1};
      tbl[6]  = '{6'b110000, 32'd9, 32'd8, 32'd77, 32'd1, 1'b0, 1'b0};
      tbl[7]  = '{6'b111111, 32'd2, 32'd3, 32'd0, 32'd5, 1'b0, 1'b0};
      tbl[8]  = '{6'b001111, 32'd1, 32'd2, 32'd9, 32'd3, 1'b0, 1'b0};
      tbl[9]  = '{6'b010001, 32'hF0F0, 32'hFF00, 32'd0, 32'hF000, 1'b0, 1'b0};
      tbl[10] = '{6'b010010, 32'hF0F0, 32'h0F00, 32'd0, 32'hFFF0, 1'b0, 1'b0};
      tbl[11] = '{6'b100000, 32'hCAFE_0000, 32'd0, 32'd4, 32'hCAFE_0000, 1'b0, 1'b0};
      tbl[12] = '{6'b000000, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0, 1'b1, 1'b0};
      for (int i = 0; i < 64; i++) mm[i] = '0;

      repeat (2) @(negedge click);
      chk("reset.dataout", DataOut, 32'd0);
      chk("reset.ins_mem_rw", {31'd0, InsMemRW}, 32'd1);
      reset = 1'b0;

      for (int i = 0; i < 13; i++) begin
         @(negedge click);
         opcode = tbl[i].op; readData1 = tbl[i].a; readData2 = tbl[i].b; immediate_32 = tbl[i].imm;
         #1;
         chk($sformatf("vec%0d.result", i), result, tbl[i].res);
         chk($sformatf("vec%0d.zero", i), {31'd0, zero}, {31'd0, tbl[i].z});
         chk($sformatf("vec%0d.pcsrc", i), {31'd0, PCSrc}, {31'd0, tbl[i].pcs});
         chk($sformatf("vec%0d.write_data", i), write_data, tbl[i].res);
         chk($sformatf("vec%0d.ctrl", i),
             {21'd0, ALUSrcB, ALUM2Reg, RegWre, InsMemRW, DataMemRW, ExtSel, RegOut, PCWre, ALUFlag},
             {21'd0, ref_ctrl(tbl[i].op)});
      end

      @(negedge click);
      opcode = 6'b100110; readData1 = 32'd8; immediate_32 = 32'd4; readData2 = 32'hDEAD_BEEF;
      #1 chk("sw.before_edge", DataOut, 32'd0);
      @(posedge click);
      #1 chk("sw.after_edge", DataOut, 32'hDEAD_BEEF);
      mm[3] = 32'hDEAD_BEEF;
      @(negedge click);
      opcode = 6'b100111; readData2 = 32'd0;
      #1;
      chk("lw.dataout", DataOut, 32'hDEAD_BEEF);
      chk("lw.write_data", write_data, 32'hDEAD_BEEF);
      chk("lw.alum2reg", {31'd0, ALUM2Reg}, 32'd1);
      chk("lw.datamemrw", {31'd0, DataMemRW}, 32'd0);
      reset = 1'b1;
      #1;
      chk("rst_mid.dataout", DataOut, 32'd0);
      chk("rst_mid.write_data", write_data, 32'd0);
      opcode = 6'b100110; readData2 = 32'h1234_5678;
      @(posedge click);
      #1 chk("rst_store.held", DataOut, 32'd0);
      @(negedge click);
      reset = 1'b0;
      opcode = 6'b100111;
      #1 chk("rst_store.dropped", DataOut, 32'd0);
      mm[3] = '0;

      for (int n = 0; n < 300; n++) begin
         logic [5:0] ops [12];
         ops = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
                 6'b100000, 6'b100110, 6'b100111, 6'b110000, 6'b111111, 6'b100110};
         @(negedge click);
         opcode       = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 11)];
         readData1    = $urandom_range(0, 1) ? 32'($urandom_range(0, 255)) : $urandom;
         readData2    = ($urandom_range(0, 3) == 0) ? readData1 : $urandom;
         immediate_32 = $urandom_range(0, 1) ? 32'($urandom_range(0, 64)) : $urandom;
         #1 check_all($sformatf("rnd%0d", n));
         if (opcode == 6'b100110) begin
            logic [31:0] r;
            r = ref_result();
            @(posedge click);
            mm[r[7:2]] = readData2;
            #1 check_all($sformatf("rnd%0d.post", n));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
